// File: rtl/handshake_cmpi_share.sv
// Several handshake requesters share one signed less-than comparator.
// A round-robin grant steers one operand pair per cycle into a per-requester result slot.
module handshake_cmpi_share #(
  parameter int DATA_TYPE = 32,
  parameter int NUM_REQ   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ*DATA_TYPE-1:0] lhs,
  input  logic [NUM_REQ-1:0]           lhs_valid,
  input  logic [NUM_REQ*DATA_TYPE-1:0] rhs,
  input  logic [NUM_REQ-1:0]           rhs_valid,
  input  logic [NUM_REQ-1:0]           result_ready,
  output logic [NUM_REQ-1:0]           result,
  output logic [NUM_REQ-1:0]           result_valid,
  output logic [NUM_REQ-1:0]           lhs_ready,
  output logic [NUM_REQ-1:0]           rhs_ready
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   result_q, result_d;
  logic [NUM_REQ-1:0]   result_valid_q, result_valid_d;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   grant;
  logic                 grant_vld;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W:0]       scan_idx;
  logic [DATA_TYPE-1:0] lhs_arr [NUM_REQ];
  logic [DATA_TYPE-1:0] rhs_arr [NUM_REQ];
  logic [DATA_TYPE-1:0] lhs_g, rhs_g;
  logic                 cmp_lt;

  // A slot that is draining this cycle can take a new result at the same edge.
  assign eligible = rst ? (lhs_valid & rhs_valid & (~result_valid_q | result_ready))
                        : '0;

  // Scan from ptr_q upward with wraparound; the first eligible index wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, ptr_q} + (PTR_W + 1)'(k);
      if (scan_idx >= NUM_REQ_W) begin
        scan_idx = scan_idx - NUM_REQ_W;
      end
      if (!grant_vld && eligible[scan_idx[PTR_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx[PTR_W-1:0];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign lhs_arr[gi]        = lhs[gi*DATA_TYPE +: DATA_TYPE];
      assign rhs_arr[gi]        = rhs[gi*DATA_TYPE +: DATA_TYPE];
      assign grant[gi]          = grant_vld && (grant_idx == PTR_W'(gi));
      assign result_d[gi]       = grant[gi] ? cmp_lt : result_q[gi];
      assign result_valid_d[gi] = grant[gi] | (result_valid_q[gi] & ~result_ready[gi]);
    end
  endgenerate

  // The single shared comparator.
  assign lhs_g  = lhs_arr[grant_idx];
  assign rhs_g  = rhs_arr[grant_idx];
  assign cmp_lt = $signed(lhs_g) < $signed(rhs_g);

  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q          <= '0;
      result_q       <= '0;
      result_valid_q <= '0;
    end else begin
      ptr_q          <= ptr_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign lhs_ready    = grant;
  assign rhs_ready    = grant;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_handshake_cmpi_share.sv
// Scoreboard bench for handshake_cmpi_share: a 2x32 and a 4x8 instance share one
// stimulus harness; `sel` picks which one is driven and observed.
module tb_handshake_cmpi_share;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic [31:0] cur_l [4];
  logic [31:0] cur_r [4];
  logic [3:0]  cur_lv, cur_rv, cur_rr;

  logic [31:0] stg_l [4];
  logic [31:0] stg_r [4];
  logic        stg_rst, stg_sel;

  // Instance A: NUM_REQ=2, DATA_TYPE=32
  logic [63:0] lhs_a, rhs_a;
  logic [1:0]  lv_a, rv_a, rr_a, res_a, resv_a, lrdy_a, rrdy_a;
  assign lhs_a = {cur_l[1], cur_l[0]};
  assign rhs_a = {cur_r[1], cur_r[0]};
  assign lv_a  = sel ? 2'b00 : cur_lv[1:0];
  assign rv_a  = sel ? 2'b00 : cur_rv[1:0];
  assign rr_a  = sel ? 2'b00 : cur_rr[1:0];

  handshake_cmpi_share #(.DATA_TYPE(32), .NUM_REQ(2)) dut_a (
    .clk(clk), .rst(rst),
    .lhs(lhs_a), .lhs_valid(lv_a), .rhs(rhs_a), .rhs_valid(rv_a),
    .result_ready(rr_a), .result(res_a), .result_valid(resv_a),
    .lhs_ready(lrdy_a), .rhs_ready(rrdy_a)
  );

  // Instance B: NUM_REQ=4, DATA_TYPE=8
  logic [31:0] lhs_b, rhs_b;
  logic [3:0]  lv_b, rv_b, rr_b, res_b, resv_b, lrdy_b, rrdy_b;
  assign lhs_b = {cur_l[3][7:0], cur_l[2][7:0], cur_l[1][7:0], cur_l[0][7:0]};
  assign rhs_b = {cur_r[3][7:0], cur_r[2][7:0], cur_r[1][7:0], cur_r[0][7:0]};
  assign lv_b  = sel ? cur_lv : 4'b0000;
  assign rv_b  = sel ? cur_rv : 4'b0000;
  assign rr_b  = sel ? cur_rr : 4'b0000;

  handshake_cmpi_share #(.DATA_TYPE(8), .NUM_REQ(4)) dut_b (
    .clk(clk), .rst(rst),
    .lhs(lhs_b), .lhs_valid(lv_b), .rhs(rhs_b), .rhs_valid(rv_b),
    .result_ready(rr_b), .result(res_b), .result_valid(resv_b),
    .lhs_ready(lrdy_b), .rhs_ready(rrdy_b)
  );

  logic [3:0] act_res, act_v, act_lr, act_rr;
  assign act_res = sel ? res_b  : {2'b00, res_a};
  assign act_v   = sel ? resv_b : {2'b00, resv_a};
  assign act_lr  = sel ? lrdy_b : {2'b00, lrdy_a};
  assign act_rr  = sel ? rrdy_b : {2'b00, rrdy_a};

  // Reference model state: slot occupancy, last delivered value, pending results.
  int         n_tests = 0;
  int         n_fail  = 0;
  int         ptr_m;
  bit         occ      [4];
  bit         last_val [4];
  bit         exp_q    [4][$];
  bit         mon_en;
  logic [3:0] last_grant;

  function automatic longint sx(input logic [31:0] v, input int w);
    longint m;
    longint x;
    m = (longint'(1) << w) - 1;
    x = longint'(v) & m;
    if (x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] l, input logic [31:0] r);
    stg_l[i] = l;
    stg_r[i] = r;
  endtask

  // One clock cycle: apply staged inputs at the falling edge, then predict the
  // grant from the arbitration rules and check both ready vectors.
  task automatic tick(input logic [3:0] lvi, input logic [3:0] rvi, input logic [3:0] rri);
    int         n;
    int         w;
    int         idx;
    logic [3:0] exp_g;
    @(negedge clk);
    rst    = stg_rst;
    sel    = stg_sel;
    cur_lv = lvi;
    cur_rv = rvi;
    cur_rr = rri;
    for (int i = 0; i < 4; i++) begin
      cur_l[i] = stg_l[i];
      cur_r[i] = stg_r[i];
    end
    #3;
    n = sel ? 4 : 2;
    w = sel ? 8 : 32;
    exp_g = '0;
    if (rst) begin
      for (int k = 0; k < n; k++) begin
        idx = (ptr_m + k) % n;
        if (exp_g == 4'b0 && cur_lv[idx] && cur_rv[idx] && (!occ[idx] || cur_rr[idx]))
          exp_g[idx] = 1'b1;
      end
    end
    chk("lhs_ready", 32'(act_lr), 32'(exp_g));
    chk("rhs_ready", 32'(act_rr), 32'(exp_g));
    last_grant = act_lr;
    if (!rst) begin
      ptr_m = 0;
      for (int i = 0; i < 4; i++) begin
        occ[i] = 1'b0;
        last_val[i] = 1'b0;
        exp_q[i].delete();
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        if (exp_g[i]) begin
          bit lt;
          lt = sx(cur_l[i], w) < sx(cur_r[i], w);
          exp_q[i].push_back(lt);
          last_val[i] = lt;
          occ[i] = 1'b1;
          ptr_m = (i + 1) % n;
        end else if (occ[i] && cur_rr[i]) begin
          occ[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    stg_rst = 1'b0;
    tick(4'h0, 4'h0, 4'h0);
    tick(4'h0, 4'h0, 4'h0);
    stg_rst = 1'b1;
  endtask

  task automatic rand_phase(input int cycles);
    logic [31:0] edge_vals [4];
    edge_vals[0] = 32'h8000_0000;
    edge_vals[1] = 32'h7FFF_FFFF;
    edge_vals[2] = 32'h0000_0080;
    edge_vals[3] = 32'h0000_007F;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < 4; i++) begin
        stg_l[i] = ($urandom_range(0, 5) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
        stg_r[i] = ($urandom_range(0, 5) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
        if ($urandom_range(0, 7) == 0) stg_r[i] = stg_l[i];
      end
      tick(4'($urandom | $urandom), 4'($urandom | $urandom), 4'($urandom | $urandom));
    end
  endtask

  // Monitor: compares every observed slot against the model each cycle and
  // retires a scoreboard entry whenever the consumer takes a result.
  initial begin
    int mon_n;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        mon_n = sel ? 4 : 2;
        for (int i = 0; i < mon_n; i++) begin
          chk("result_valid", 32'(act_v[i]), 32'(occ[i]));
          if (act_v[i]) begin
            if (exp_q[i].size() == 0) begin
              n_tests++;
              n_fail++;
              $display("[TB] FAIL scoreboard: req%0d presented result %0b, expected no result", i, act_res[i]);
            end else begin
              chk("result", 32'(act_res[i]), 32'(exp_q[i][0]));
              if (cur_rr[i]) begin
                $display("[TB] cfg%0d req%0d result=%0b taken", sel, i, act_res[i]);
                void'(exp_q[i].pop_front());
              end
            end
          end else begin
            chk("result_hold", 32'(act_res[i]), 32'(last_val[i]));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0; sel = 1'b0; stg_rst = 1'b0; stg_sel = 1'b0;
    cur_lv = '0; cur_rv = '0; cur_rr = '0;
    mon_en = 1'b0; ptr_m = 0; last_grant = '0;
    for (int i = 0; i < 4; i++) begin
      cur_l[i] = '0; cur_r[i] = '0; stg_l[i] = '0; stg_r[i] = '0;
      occ[i] = 1'b0; last_val[i] = 1'b0;
    end

    // Single requester on the 2x32 instance
    do_reset();
    mon_en = 1'b1;
    set_op(0, 32'hFFFF_FFFB, 32'd3);
    tick(4'h1, 4'h1, 4'h1);
    chk("single_grant", 32'(last_grant), 32'h1);
    tick(4'h0, 4'h0, 4'h1);
    chk("single_slot", 32'({act_v[0], act_res[0]}), 32'b11);
    set_op(0, 32'd3, 32'hFFFF_FFFB);
    tick(4'h1, 4'h1, 4'h1);
    tick(4'h0, 4'h0, 4'h1);
    chk("swap_slot", 32'({act_v[0], act_res[0]}), 32'b10);

    // Contention from reset: grants alternate 0,1,0,1
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_op(0, $urandom, $urandom);
      set_op(1, $urandom, $urandom);
      tick(4'h3, 4'h3, 4'h3);
      chk("contention_grant", 32'(last_grant), (k % 2 == 1) ? 32'h2 : 32'h1);
    end

    // Backpressure on requester 1
    do_reset();
    tick(4'h2, 4'h2, 4'h1);
    chk("bp_fill", 32'(last_grant), 32'h2);
    for (int k = 0; k < 10; k++) begin
      set_op(0, $urandom, $urandom);
      tick(4'h3, 4'h3, 4'h1);
      chk("bp_grant0", 32'(last_grant), 32'h1);
    end
    set_op(1, 32'hFFFF_FF00, 32'h0000_0001);
    tick(4'h3, 4'h3, 4'h3);
    chk("bp_release", 32'(last_grant), 32'h2);
    tick(4'h0, 4'h0, 4'h0);
    chk("bp_refill", 32'({act_v[1], act_res[1]}), 32'b11);

    // Partial join on requester 0
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick(4'h1, 4'h0, 4'h1);
      chk("partial_idle", 32'(last_grant), 32'h0);
    end
    tick(4'h1, 4'h1, 4'h0);
    chk("partial_join", 32'(last_grant), 32'h1);

    // Reset with both slots full
    tick(4'h3, 4'h3, 4'h0);
    tick(4'h3, 4'h3, 4'h0);
    chk("mid_full", 32'(act_v), 32'h3);
    stg_rst = 1'b0;
    tick(4'h3, 4'h3, 4'h0);
    stg_rst = 1'b1;
    tick(4'h3, 4'h3, 4'h3);
    chk("reset_clear", 32'({act_v, act_res}), 32'h0);
    chk("reset_first_grant", 32'(last_grant), 32'h1);

    rand_phase(200);

    // Switch to the 4x8 instance
    mon_en = 1'b0;
    stg_sel = 1'b1;
    do_reset();
    mon_en = 1'b1;
    set_op(1, 32'h80, 32'h7F);
    tick(4'h2, 4'h2, 4'h0);
    chk("bnd_grant1", 32'(last_grant), 32'h2);
    set_op(2, 32'h7F, 32'h80);
    tick(4'h4, 4'h4, 4'h0);
    chk("bnd_grant2", 32'(last_grant), 32'h4);
    set_op(3, 32'h05, 32'h05);
    tick(4'h8, 4'h8, 4'h0);
    chk("bnd_grant3", 32'(last_grant), 32'h8);
    tick(4'h0, 4'h0, 4'h0);
    chk("bnd_valid", 32'(act_v), 32'hE);
    chk("bnd_result", 32'(act_res), 32'h2);
    tick(4'h0, 4'h0, 4'hF);

    rand_phase(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/handshake_cmpi_share.md
# handshake_cmpi_share

Time-multiplexes one signed less-than comparator (`lhs < rhs`, two's complement) among `NUM_REQ` independent handshake requesters. A round-robin arbiter issues at most one comparison per cycle and the result is written into a per-requester one-entry output slot. Used in dataflow circuits where several `cmpi slt` operations are folded onto one comparator to save area. Each requester port keeps the same valid/ready join semantics as a dedicated comparator unit, at the cost of one cycle of latency.

## Interface
- `DATA_TYPE`, 32, operand width in bits.
- `NUM_REQ`, 2, number of requesters; legal range 2..8.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset (`rst`=0 at a rising edge resets).
- `lhs`  in  `NUM_REQ*DATA_TYPE`  left operands; requester i occupies bits `[i*DATA_TYPE +: DATA_TYPE]`.
- `lhs_valid`  in  `NUM_REQ`  left operand valid, bit i per requester.
- `rhs`  in  `NUM_REQ*DATA_TYPE`  right operands, same packing as `lhs`.
- `rhs_valid`  in  `NUM_REQ`  right operand valid.
- `result_ready`  in  `NUM_REQ`  consumer ready, per requester.
- `result`  out  `NUM_REQ`  registered comparison result, bit i for requester i.
- `result_valid`  out  `NUM_REQ`  output slot i full.
- `lhs_ready`  out  `NUM_REQ`  left operand accepted this cycle.
- `rhs_ready`  out  `NUM_REQ`  right operand accepted this cycle.

## Operation
- Requester i is eligible when all of the following hold:
  - `lhs_valid[i]` and `rhs_valid[i]` are both high (join).
  - Slot i can accept: `!result_valid[i] || result_ready[i]`.
- Arbiter state is a round-robin pointer `ptr` (width `$clog2(NUM_REQ)`).
  - Grant goes to the first eligible index scanning `ptr`, `ptr+1`, … modulo `NUM_REQ`.
  - At most one grant per cycle, one-hot or zero.
- Granted requester g:
  - `lhs_ready[g]` = `rhs_ready[g]` = 1, so both operands are consumed in the same cycle.
  - All other ready bits are 0.
  - No grant means all ready bits are 0.
- Comparator: one instance, inputs muxed by the grant index, `$signed(lhs_g) < $signed(rhs_g)`.
- Slot update per index i, each edge:
  - Grant to i: `result[i]` ← compare output, `result_valid[i]` ← 1. This applies even when slot i is draining that same cycle; the slot refills.
  - Else, if `result_valid[i] && result_ready[i]`: `result_valid[i]` ← 0, `result[i]` holds its last value.
- Pointer: on a grant to g, `ptr` ← (g+1) mod `NUM_REQ`. With no grant, `ptr` holds.
- Readies depend combinationally on the valids and `result_ready`. Valids never depend on readies (no combinational loop through the block).
- A requester that asserts only one of `lhs_valid`/`rhs_valid` is never granted and its ready bits stay 0.
- Reset (`rst`=0): `result_valid` = 0, `result` = 0, `ptr` = 0. `lhs_ready`/`rhs_ready` are forced to 0 while `rst`=0. Any in-flight slot contents are discarded.

## Timing
- Latency: operands accepted at edge N produce `result_valid` high after edge N; visible in cycle N+1.
- Throughput: one comparison per cycle in aggregate. A single requester with a continuously ready consumer sustains one result per cycle.
- Fairness: a continuously eligible requester is granted within `NUM_REQ` cycles.
- First cycle after reset release: arbitration is live, with priority starting at index 0.
- Width: `DATA_TYPE`=1 is legal (signed, values 0 and -1).

## Test plan
- Single requester, `NUM_REQ`=2: req0 `lhs`=-5 (0xFFFFFFFB), `rhs`=3, both valid, `result_ready`=1.
  - Cycle 0: `lhs_ready[0]`=1.
  - Cycle 1: `result[0]`=1, `result_valid[0]`=1.
  - Swapping operands gives `result[0]`=0.
- Contention: req0 and req1 continuously valid, both consumers ready. Grants alternate 0,1,0,1 from reset, and each port receives exactly one result every 2 cycles.
- Backpressure: req1 `result_ready`=0 with slot 1 full.
  - req1 is never granted, and `lhs_ready[1]` stays 0 for 10 cycles.
  - req0 is granted every cycle.
  - Raising `result_ready[1]` gives a grant to req1 in that same cycle and a refilled slot the next cycle.
- Partial join: `lhs_valid[0]`=1, `rhs_valid[0]`=0 for 5 cycles, then `rhs_valid[0]`=1.
  - No ready bits during the 5 cycles.
  - `lhs_ready[0]` and `rhs_ready[0]` rise together in the 6th cycle.
- Reset mid-operation: slots 0 and 1 full, then `rst`=0 for one edge.
  - Next cycle `result_valid`=0 and `result`=0.
  - With both requesters valid, the first grant goes to index 0.
- Boundary values, `NUM_REQ`=4, `DATA_TYPE`=8:
  - (-128 < 127) → 1.
  - (127 < -128) → 0.
  - (5 < 5) → 0.
  - Each case is issued on a different requester, and every result must land only in that requester's slot.
